// File: rtl/fft_pkg.sv
// fft_pkg: shared constants, complex types and the saturation helper for
// the radix-2 butterfly datapath.
//   DW       - width of each real/imag data component
//   TW_W     - width of each twiddle component (Q1.14, 16384 = +1.0)
//   TW_FRAC  - twiddle fractional bits, removed after the multiply
//   ROUND_K  - half-LSB constant for round-half-up before the shift
//   PW       - width of the rounded complex product (DW+2)
//   SW       - width of the butterfly sums (DW+3)
package fft_pkg;

   localparam int DW      = 16;
   localparam int TW_W    = 16;
   localparam int TW_FRAC = 14;
   localparam int ROUND_K = 1 << (TW_FRAC - 1);
   localparam int PW      = DW + 2;
   localparam int SW      = DW + 3;

   typedef struct packed {
      logic signed [DW-1:0] re;
      logic signed [DW-1:0] im;
   } cplx_t;

   typedef struct packed {
      logic signed [TW_W-1:0] re;
      logic signed [TW_W-1:0] im;
   } tw_t;

   // Clamp a butterfly sum into the signed DW-bit output range.
   function automatic logic signed [DW-1:0] saturate(input logic signed [SW-1:0] v);
      logic signed [SW-1:0] hi;
      logic signed [SW-1:0] lo;
      hi = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
      lo = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};
      if (v > hi)
         return hi[DW-1:0];
      else if (v < lo)
         return lo[DW-1:0];
      else
         return v[DW-1:0];
   endfunction

endpackage

// File: rtl/fft_cmul.sv
// fft_cmul: first two pipeline stages of the butterfly.
//   S1 registers A and the four partial products of B*W.
//   S2 combines them into Pr/Pi, rounds half-up, drops TW_FRAC bits and
//   registers the PW-bit result together with A.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   in_valid          - beat valid entering S1
//   en1, en2          - stage load enables from the top-level enable chain
//   a_in, b_in, w_in  - packed {re, im} operands
//   v1, v2            - S1 / S2 valid flags (feed the enable chain)
//   a_out             - A as held in S2
//   pr_out, pi_out    - rounded W*B real/imag held in S2
module fft_cmul
   import fft_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic                 en1,
   input  logic                 en2,
   input  logic [2*DW-1:0]      a_in,
   input  logic [2*DW-1:0]      b_in,
   input  logic [2*TW_W-1:0]    w_in,
   output logic                 v1,
   output logic                 v2,
   output logic [2*DW-1:0]      a_out,
   output logic signed [PW-1:0] pr_out,
   output logic signed [PW-1:0] pi_out
);

   cplx_t b_c;
   tw_t   w_c;
   assign b_c = b_in;
   assign w_c = w_in;

   // Product lanes: 0 = Br*Wr, 1 = Bi*Wi, 2 = Br*Wi, 3 = Bi*Wr
   logic signed [DW-1:0]   mul_b [4];
   logic signed [TW_W-1:0] mul_w [4];
   logic signed [2*DW-1:0] prod_reg [4];

   assign mul_b[0] = b_c.re;  assign mul_w[0] = w_c.re;
   assign mul_b[1] = b_c.im;  assign mul_w[1] = w_c.im;
   assign mul_b[2] = b_c.re;  assign mul_w[2] = w_c.im;
   assign mul_b[3] = b_c.im;  assign mul_w[3] = w_c.re;

   logic            v1_reg;
   logic [2*DW-1:0] a1_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_reg <= 1'b0;
         a1_reg <= '0;
      end else if (en1) begin
         v1_reg <= in_valid;
         a1_reg <= a_in;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_mul
         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               prod_reg[gi] <= '0;
            else if (en1)
               prod_reg[gi] <= mul_b[gi] * mul_w[gi];
         end
      end
   endgenerate

   // S2 combine and round. The rounded value is bits [TW_FRAC +: PW] of the
   // sum-plus-half, which equals an arithmetic shift followed by truncation.
   logic signed [2*DW:0] pr_full;
   logic signed [2*DW:0] pi_full;
   logic signed [2*DW:0] pr_rnd;
   logic signed [2*DW:0] pi_rnd;

   assign pr_full = {prod_reg[0][2*DW-1], prod_reg[0]} - {prod_reg[1][2*DW-1], prod_reg[1]};
   assign pi_full = {prod_reg[2][2*DW-1], prod_reg[2]} + {prod_reg[3][2*DW-1], prod_reg[3]};
   assign pr_rnd  = pr_full + (2*DW+1)'(ROUND_K);
   assign pi_rnd  = pi_full + (2*DW+1)'(ROUND_K);

   // Fraction bits and the top guard bit are dropped on purpose.
   logic unused_bits;
   assign unused_bits = ^{pr_rnd[TW_FRAC-1:0], pi_rnd[TW_FRAC-1:0],
                          pr_rnd[2*DW], pi_rnd[2*DW]};

   logic                 v2_reg;
   logic [2*DW-1:0]      a2_reg;
   logic signed [PW-1:0] pr_reg;
   logic signed [PW-1:0] pi_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v2_reg <= 1'b0;
         a2_reg <= '0;
         pr_reg <= '0;
         pi_reg <= '0;
      end else if (en2) begin
         v2_reg <= v1_reg;
         a2_reg <= a1_reg;
         pr_reg <= pr_rnd[TW_FRAC +: PW];
         pi_reg <= pi_rnd[TW_FRAC +: PW];
      end
   end

   assign v1     = v1_reg;
   assign v2     = v2_reg;
   assign a_out  = a2_reg;
   assign pr_out = pr_reg;
   assign pi_out = pi_reg;

endmodule

// File: rtl/fft_bf2_stage.sv
// fft_bf2_stage: radix-2 DIT butterfly, X = A + W*B, Y = A - W*B.
// Three register stages (S1/S2 in fft_cmul, S3 here), one beat per cycle,
// valid/ready on both sides with a collapsing-bubble enable chain.
// Build option: define FFT_BF_SCALE_EN to halve every S3 sum (round half-up)
// before saturation; left undefined, sums are saturated unscaled.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   in_valid, in_ready  - input handshake (in_ready independent of in_valid)
//   a_in, b_in          - packed {re, im} data, re in upper half
//   w_in                - packed Q1.14 twiddle {re, im}
//   out_valid, out_ready- output handshake
//   x_out, y_out        - packed {re, im} butterfly results
module fft_bf2_stage
   import fft_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2*DW-1:0]   a_in,
   input  logic [2*DW-1:0]   b_in,
   input  logic [2*TW_W-1:0] w_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [2*DW-1:0]   x_out,
   output logic [2*DW-1:0]   y_out
);

   logic v1, v2, v3_reg;
   logic en1, en2, en3;

   // A stage may load whenever it is empty or its content moves on this cycle.
   assign en3      = !v3_reg || out_ready;
   assign en2      = !v2 || en3;
   assign en1      = !v1 || en2;
   assign in_ready = en1;

   logic [2*DW-1:0]      a2_bits;
   logic signed [PW-1:0] pr, pi;

   fft_cmul u_cmul (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .en1      (en1),
      .en2      (en2),
      .a_in     (a_in),
      .b_in     (b_in),
      .w_in     (w_in),
      .v1       (v1),
      .v2       (v2),
      .a_out    (a2_bits),
      .pr_out   (pr),
      .pi_out   (pi)
   );

   cplx_t a2_c;
   assign a2_c = a2_bits;

   // Index 0 = real, 1 = imaginary, both sign-extended to the sum width.
   logic signed [SW-1:0] a_ext [2];
   logic signed [SW-1:0] p_ext [2];
   assign a_ext[0] = {{(SW-DW){a2_c.re[DW-1]}}, a2_c.re};
   assign a_ext[1] = {{(SW-DW){a2_c.im[DW-1]}}, a2_c.im};
   assign p_ext[0] = {{(SW-PW){pr[PW-1]}}, pr};
   assign p_ext[1] = {{(SW-PW){pi[PW-1]}}, pi};

   // Output lanes: 0 = Xr, 1 = Xi, 2 = Yr, 3 = Yi
   logic signed [DW-1:0] res_reg [4];

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic signed [SW-1:0] sum_w;
         logic signed [SW-1:0] scl_w;

         if (gi < 2) begin : g_add
            assign sum_w = a_ext[gi % 2] + p_ext[gi % 2];
         end else begin : g_sub
            assign sum_w = a_ext[gi % 2] - p_ext[gi % 2];
         end

`ifdef FFT_BF_SCALE_EN
         assign scl_w = (sum_w + SW'(1)) >>> 1;
`else
         assign scl_w = sum_w;
`endif

         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               res_reg[gi] <= '0;
            else if (en3)
               res_reg[gi] <= saturate(scl_w);
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         v3_reg <= 1'b0;
      else if (en3)
         v3_reg <= v2;
   end

   assign out_valid = v3_reg;
   assign x_out     = {res_reg[0], res_reg[1]};
   assign y_out     = {res_reg[2], res_reg[3]};

endmodule

// File: tb/tb_fft_bf2_stage.sv
// tb_fft_bf2_stage: directed self-checking bench for fft_bf2_stage.
// Expected butterfly sums are hand-computed before output scaling; the
// exp_c helper applies the optional 1/2 scaling (when FFT_BF_SCALE_EN is
// defined for the build) and output saturation.
module tb_fft_bf2_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a_in, b_in, w_in;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] x_out, y_out;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fft_bf2_stage dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a_in      (a_in),
      .b_in      (b_in),
      .w_in      (w_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .x_out     (x_out),
      .y_out     (y_out)
   );

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] pack(input int re, input int im);
      logic [15:0] r, i;
      r = re[15:0];
      i = im[15:0];
      return {r, i};
   endfunction

   function automatic logic signed [31:0] re_of(input logic [31:0] v);
      return {{16{v[31]}}, v[31:16]};
   endfunction

   function automatic logic signed [31:0] im_of(input logic [31:0] v);
      return {{16{v[15]}}, v[15:0]};
   endfunction

   function automatic int exp_c(input int v);
      int t;
      t = v;
`ifdef FFT_BF_SCALE_EN
      t = (t + 1) >>> 1;
`endif
      if (t > 32767)  return 32767;
      if (t < -32768) return -32768;
      return t;
   endfunction

   // One isolated beat: check acceptance, 3-cycle latency and X/Y values.
   task automatic run_one(input string tag, input int ar, input int ai, input int br, input int bi,
                          input int wr, input int wi, input int xr, input int xi, input int yr, input int yi);
      int n;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      a_in = pack(ar, ai);
      b_in = pack(br, bi);
      w_in = pack(wr, wi);
      #1;
      chk({tag, "_in_ready"}, in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 1;
      while (out_valid !== 1'b1 && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_latency"}, n, 3);
      $display("%s: X=(%0d,%0d) Y=(%0d,%0d) latency=%0d", tag,
               re_of(x_out), im_of(x_out), re_of(y_out), im_of(y_out), n);
      chk({tag, "_xr"}, re_of(x_out), exp_c(xr));
      chk({tag, "_xi"}, im_of(x_out), exp_c(xi));
      chk({tag, "_yr"}, re_of(y_out), exp_c(yr));
      chk({tag, "_yi"}, im_of(y_out), exp_c(yi));
      @(posedge clk); #1;
   endtask

   initial begin
      int acc, outc, first, last, quiet;
      bit dropped, held_v, acc_now;
      logic [31:0] hx, hy;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      a_in = '0; b_in = '0; w_in = '0;
      #12;
      chk("reset_out_valid", out_valid, 0);
      chk("reset_x_out", x_out, 0);
      chk("reset_y_out", y_out, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("reset_in_ready", in_ready, 1);
      @(posedge clk); #1;

      // Directed butterflies (sums are unscaled hand values)
      run_one("identity", 100, 50, 20, -10, 16384, 0, 120, 40, 80, 60);
      run_one("minus_j", 100, 50, 20, -10, 0, -16384, 90, 30, 110, 70);
      run_one("rounding", 0, 0, 1000, 0, 11585, -11585, 707, -707, -707, 707);
      run_one("saturate", 32767, 0, 32767, 0, 16384, 0, 65534, 0, 0, 0);

      // Backpressure: six beats offered back to back, out_ready low for 5 cycles.
      // Beat i: A=(100i,7), B=(i+1,-i), W=1 -> X=(101i+1,7-i), Y=(99i-1,7+i).
      acc = 0; outc = 0; first = -1; last = -1;
      dropped = 1'b0; held_v = 1'b0; hx = '0; hy = '0;
      for (int cyc = 0; cyc < 40 && outc < 6; cyc++) begin
         in_valid  = (acc < 6);
         a_in      = pack(100 * acc, 7);
         b_in      = pack(acc + 1, -acc);
         w_in      = pack(16384, 0);
         out_ready = (cyc >= 5);
         #2;
         if (!in_ready && !dropped) begin
            dropped = 1'b1;
            chk("bp_inready_drop_after", acc, 3);
         end
         if (held_v && out_valid) begin
            chk("bp_hold_x", x_out, hx);
            chk("bp_hold_y", y_out, hy);
         end
         held_v = out_valid && !out_ready;
         hx = x_out;
         hy = y_out;
         if (out_valid && out_ready) begin
            $display("bp beat %0d cycle %0d: X=(%0d,%0d) Y=(%0d,%0d)", outc, cyc,
                     re_of(x_out), im_of(x_out), re_of(y_out), im_of(y_out));
            chk("bp_xr", re_of(x_out), exp_c(101 * outc + 1));
            chk("bp_xi", im_of(x_out), exp_c(7 - outc));
            chk("bp_yr", re_of(y_out), exp_c(99 * outc - 1));
            chk("bp_yi", im_of(y_out), exp_c(7 + outc));
            if (first < 0) first = cyc;
            last = cyc;
            outc++;
         end
         acc_now = in_valid && in_ready;
         @(posedge clk); #1;
         if (acc_now) acc++;
      end
      chk("bp_in_ready_dropped", dropped, 1);
      chk("bp_out_count", outc, 6);
      chk("bp_drain_span", last - first, 5);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;

      // Reset while two beats are in flight (one in S3, one in S2)
      in_valid = 1'b1;
      a_in = pack(1, 1); b_in = pack(2, 2); w_in = pack(16384, 0);
      @(posedge clk); #1;
      a_in = pack(3, 3);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("rst_pre_out_valid", out_valid, 1);
      rst = 1'b1;
      #1;
      chk("rst_async_out_valid", out_valid, 0);
      chk("rst_async_x_out", x_out, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      quiet = 0;
      for (int i = 0; i < 6; i++) begin
         if (out_valid) quiet++;
         @(posedge clk); #1;
      end
      chk("rst_no_ghost_beats", quiet, 0);
      run_one("after_reset", 100, 50, 20, -10, 16384, 0, 120, 40, 80, 60);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
